// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: freeze vectors,
// controller state encodings and the stall-priority helper.
package pipeline_ctrl_pkg;

   // Freeze vectors: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;
   localparam logic [5:0] STALL_ALL  = 6'b111111;

   // Controller state encodings
   localparam logic [1:0] PCTRL_RUN     = 2'd0;
   localparam logic [1:0] PCTRL_STALL   = 2'd1;
   localparam logic [1:0] PCTRL_TIMEOUT = 2'd2;

   // Existing enable levels
   localparam logic STALL_ENABLE = 1'b1;
   localparam logic WRITE_ENABLE = 1'b1;

   // Merge stall requests; the most downstream requester wins because its
   // freeze already covers every stage upstream of it.
   function automatic logic [5:0] stall_vector(input logic id_req,
                                               input logic ex_req,
                                               input logic mem_req);
      logic [5:0] vec;
      if (mem_req == STALL_ENABLE) begin
         vec = STALL_MEM;
      end else if (ex_req == STALL_ENABLE) begin
         vec = STALL_EX;
      end else if (id_req == STALL_ENABLE) begin
         vec = STALL_ID;
      end else begin
         vec = STALL_NONE;
      end
      return vec;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the controller's performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_r;

   // Count enabled cycles, stopping at the maximum value
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= '0;
      end else if (inc && (count_r != {W{1'b1}})) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Merges ID/EX/MEM
// stall requests into one freeze vector, gates ID's PC redirect (killing the
// wrong-path fetch), watches MEM waits and keeps saturating perf counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             id_stall_request,
   input  logic             ex_stall_request,
   input  logic             mem_stall_request,
   input  logic             id_pc_write_enable,
   input  logic [31:0]      id_pc_write_data,
   output logic [5:0]       stall,
   output logic             flush_if_id,
   output logic             pc_write_enable,
   output logic [31:0]      pc_write_data,
   output logic             mem_timeout,
   output logic             hazard_error,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_count
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   logic [1:0]        state_r;
   logic [1:0]        state_next_s;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic              mem_timeout_r;
   logic              hazard_error_r;
   logic              id_only_prev_r;
   logic              any_req_s;
   logic              id_only_s;
   logic              timeout_hit_s;
   logic              stall_any_s;

   assign any_req_s     = id_stall_request | ex_stall_request | mem_stall_request;
   // An ID stall with nothing downstream busy should clear in one cycle
   // because MEM forwarding covers the load-use case.
   assign id_only_s     = id_stall_request & ~ex_stall_request & ~mem_stall_request;
   assign timeout_hit_s = mem_stall_request & (wait_cnt_r == WAIT_W'(MAX_WAIT));
   assign stall_any_s   = (stall != STALL_NONE);

   // Freeze vector and redirect gating; a redirect seen while stalled is
   // dropped because ID re-decodes the same branch after the release.
   always_comb begin
      stall           = STALL_NONE;
      pc_write_enable = 1'b0;
      pc_write_data   = 32'h0000_0000;
      if (reset) begin
         stall           = STALL_NONE;
         pc_write_enable = 1'b0;
      end else if (state_r == PCTRL_TIMEOUT) begin
         stall           = STALL_ALL;
         pc_write_enable = 1'b0;
      end else begin
         stall = stall_vector(id_stall_request, ex_stall_request, mem_stall_request);
         if ((id_pc_write_enable == WRITE_ENABLE) && !any_req_s) begin
            pc_write_enable = WRITE_ENABLE;
            pc_write_data   = id_pc_write_data;
         end else begin
            pc_write_enable = 1'b0;
            pc_write_data   = 32'h0000_0000;
         end
      end
      flush_if_id = pc_write_enable;
   end

   // Next-state selection for the RUN/STALL/TIMEOUT controller
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         PCTRL_RUN, PCTRL_STALL: begin
            if (timeout_hit_s) begin
               state_next_s = PCTRL_TIMEOUT;
            end else if (any_req_s) begin
               state_next_s = PCTRL_STALL;
            end else begin
               state_next_s = PCTRL_RUN;
            end
         end
         PCTRL_TIMEOUT: state_next_s = PCTRL_TIMEOUT;
         default:       state_next_s = PCTRL_RUN;
      endcase
   end

   // Controller state register; TIMEOUT is left only through reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= PCTRL_RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Consecutive mem-wait counter, frozen once the watchdog has fired
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_r <= '0;
      end else if (state_r == PCTRL_TIMEOUT) begin
         wait_cnt_r <= wait_cnt_r;
      end else if (mem_stall_request) begin
         if (wait_cnt_r != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end else begin
         wait_cnt_r <= '0;
      end
   end

   // Sticky error flags: watchdog expiry and a persisting orphan ID stall
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_timeout_r  <= 1'b0;
         hazard_error_r <= 1'b0;
         id_only_prev_r <= 1'b0;
      end else begin
         mem_timeout_r  <= mem_timeout_r | (state_next_s == PCTRL_TIMEOUT);
         hazard_error_r <= hazard_error_r | (id_only_s & id_only_prev_r);
         id_only_prev_r <= id_only_s;
      end
   end

   assign mem_timeout  = mem_timeout_r;
   assign hazard_error = hazard_error_r;

   sat_counter #(.W(CNT_W)) u_stall_cycles (
      .clock (clock),
      .reset (reset),
      .inc   (stall_any_s),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_redirect_count (
      .clock (clock),
      .reset (reset),
      .inc   (pc_write_enable),
      .count (redirect_count)
   );

endmodule
